// File: rtl/ham_err_accum.sv
// ham_err_accum: accumulates per-frame Hamming distances over a programmed
// number of frames and presents the held result on a valid/ready handshake.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start           begins a run (honoured in IDLE only)
//   num_frames      frames per run, latched on accepted start
//   ham_dis         per-frame distance, qualified by in_valid / in_ready
//   bit_err_cnt     saturating sum of accepted distances
//   frame_err_cnt   count of accepted non-zero distances
//   max_dis         largest accepted distance in the run
//   range_err       sticky flag: some accepted distance exceeded BITS_PER_FRAME
//   busy            high in ACCUM and REPORT
//   out_valid       result available, held until out_ready
module ham_err_accum #(
   parameter int unsigned DIS_W          = 4,
   parameter int unsigned BITS_PER_FRAME = 12,
   parameter int unsigned FRM_W          = 16,
   parameter int unsigned CNT_W          = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [FRM_W-1:0] num_frames,
   input  logic [DIS_W-1:0] ham_dis,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CNT_W-1:0] bit_err_cnt,
   output logic [FRM_W-1:0] frame_err_cnt,
   output logic [DIS_W-1:0] max_dis,
   output logic             range_err,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_REPORT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
   logic [FRM_W-1:0] frame_err_cnt_q, frame_err_cnt_d;
   logic [DIS_W-1:0] max_dis_q, max_dis_d;
   logic             range_err_q, range_err_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [FRM_W-1:0] num_frames_q, num_frames_d;

   logic             xfer;
   logic             last_xfer;
   logic             start_ok;
   logic [FRM_W-1:0] frame_cnt_inc;
   logic [SUM_W-1:0] sum_ext;

   // Handshake decode; in_ready_q is high exactly when the FSM is in ACCUM.
   assign xfer          = in_valid & in_ready_q;
   assign frame_cnt_inc = frame_cnt_q + FRM_W'(1);
   assign last_xfer     = xfer & (frame_cnt_inc == num_frames_q);
   assign start_ok      = (state_q == S_IDLE) & start;
   assign sum_ext       = {1'b0, bit_err_cnt_q} + SUM_W'(ham_dis);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (num_frames == '0) ? S_REPORT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (last_xfer) begin
               state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            if (out_valid_q && out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they register in step with it.
   always_comb begin
      in_ready_d  = 1'b0;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
      case (state_d)
         S_ACCUM: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
         end
         S_REPORT: begin
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Accumulator datapath: cleared on accepted start, updated per transfer.
   always_comb begin
      bit_err_cnt_d   = bit_err_cnt_q;
      frame_err_cnt_d = frame_err_cnt_q;
      max_dis_d       = max_dis_q;
      range_err_d     = range_err_q;
      frame_cnt_d     = frame_cnt_q;
      num_frames_d    = num_frames_q;
      if (start_ok) begin
         bit_err_cnt_d   = '0;
         frame_err_cnt_d = '0;
         max_dis_d       = '0;
         range_err_d     = 1'b0;
         frame_cnt_d     = '0;
         num_frames_d    = num_frames;
      end else if (xfer) begin
         // Carry out of the widened sum means the accumulator would wrap.
         bit_err_cnt_d = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
         if (ham_dis != '0) begin
            frame_err_cnt_d = frame_err_cnt_q + FRM_W'(1);
         end
         if (ham_dis > max_dis_q) begin
            max_dis_d = ham_dis;
         end
         if (ham_dis > DIS_W'(BITS_PER_FRAME)) begin
            range_err_d = 1'b1;
         end
         frame_cnt_d = frame_cnt_inc;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_q      <= 1'b0;
         busy_q          <= 1'b0;
         out_valid_q     <= 1'b0;
         bit_err_cnt_q   <= '0;
         frame_err_cnt_q <= '0;
         max_dis_q       <= '0;
         range_err_q     <= 1'b0;
         frame_cnt_q     <= '0;
         num_frames_q    <= '0;
      end else begin
         in_ready_q      <= in_ready_d;
         busy_q          <= busy_d;
         out_valid_q     <= out_valid_d;
         bit_err_cnt_q   <= bit_err_cnt_d;
         frame_err_cnt_q <= frame_err_cnt_d;
         max_dis_q       <= max_dis_d;
         range_err_q     <= range_err_d;
         frame_cnt_q     <= frame_cnt_d;
         num_frames_q    <= num_frames_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign busy          = busy_q;
   assign out_valid     = out_valid_q;
   assign bit_err_cnt   = bit_err_cnt_q;
   assign frame_err_cnt = frame_err_cnt_q;
   assign max_dis       = max_dis_q;
   assign range_err     = range_err_q;

endmodule

// File: tb/tb_ham_err_accum.sv
// tb_ham_err_accum: randomized self-checking bench for ham_err_accum.
// Two instances share all inputs: the default build and a 4-bit accumulator
// build, so every run also exercises bit-error saturation.
module tb_ham_err_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num_frames;
   logic [3:0]  ham_dis;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready, busy, out_valid, range_err;
   logic [23:0] bit_err_cnt;
   logic [15:0] frame_err_cnt;
   logic [3:0]  max_dis;

   logic        s_in_ready, s_busy, s_out_valid, s_range_err;
   logic [3:0]  s_bit_err_cnt;
   logic [15:0] s_frame_err_cnt;
   logic [3:0]  s_max_dis;

   int n_tests = 0;
   int n_fail  = 0;
   int dq[$];

   always #5 clk = ~clk;

   ham_err_accum u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_frames(num_frames),
      .ham_dis(ham_dis), .in_valid(in_valid), .in_ready(in_ready),
      .bit_err_cnt(bit_err_cnt), .frame_err_cnt(frame_err_cnt),
      .max_dis(max_dis), .range_err(range_err), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   ham_err_accum #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .num_frames(num_frames),
      .ham_dis(ham_dis), .in_valid(in_valid), .in_ready(s_in_ready),
      .bit_err_cnt(s_bit_err_cnt), .frame_err_cnt(s_frame_err_cnt),
      .max_dis(s_max_dis), .range_err(s_range_err), .busy(s_busy),
      .out_valid(s_out_valid), .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares both instances against the expected result of the current run.
   task automatic check_result(input string tag, input int sum, input int ferr,
                               input int mx, input bit rerr);
      int sat24, sat4;
      sat24 = (sum > 16777215) ? 16777215 : sum;
      sat4  = (sum > 15) ? 15 : sum;
      check({tag, ".bit_err_cnt"},     32'(bit_err_cnt),     32'(sat24));
      check({tag, ".sat_bit_err_cnt"}, 32'(s_bit_err_cnt),   32'(sat4));
      check({tag, ".frame_err_cnt"},   32'(frame_err_cnt),   32'(ferr));
      check({tag, ".sat_frame_err"},   32'(s_frame_err_cnt), 32'(ferr));
      check({tag, ".max_dis"},         32'(max_dis),         32'(mx));
      check({tag, ".sat_max_dis"},     32'(s_max_dis),       32'(mx));
      check({tag, ".range_err"},       32'(range_err),       32'(rerr));
      check({tag, ".sat_range_err"},   32'(s_range_err),     32'(rerr));
   endtask

   // One complete run over the distances held in dq.
   task automatic run_frames(input int n, input bit gaps, input int bp);
      int  sum = 0, ferr = 0, mx = 0;
      bit  rerr = 1'b0;
      int  idx = 0, iters = 0, rdy = 0;
      bit  xfer;
      foreach (dq[i]) begin
         sum += dq[i];
         if (dq[i] != 0) ferr++;
         if (dq[i] > mx) mx = dq[i];
         if (dq[i] > 12) rerr = 1'b1;
      end

      start      = 1'b1;
      num_frames = 16'(n);
      out_ready  = (bp == 0);
      tick();
      start      = 1'b0;
      num_frames = 16'($urandom);
      check("start.busy",      32'(busy),      32'd1);
      check("start.range_clr", 32'(range_err), 32'd0);
      check("start.bits_clr",  32'(bit_err_cnt), 32'd0);

      if (n == 0) begin
         check("zero.in_ready", 32'(in_ready), 32'd0);
      end else begin
         check("start.in_ready", 32'(in_ready), 32'd1);
         while (idx < n && iters < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ham_dis  = in_valid ? 4'(dq[idx]) : 4'($urandom);
            start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer     = in_valid && in_ready;
            if (in_ready) rdy++;
            iters++;
            tick();
            if (xfer) idx++;
         end
         in_valid = 1'b0;
         start    = 1'b0;
         check("accum.frames_taken",    32'(idx),      32'(n));
         check("accum.in_ready_cycles", 32'(rdy),      32'(iters));
         check("accum.in_ready_low",    32'(in_ready), 32'd0);
      end

      check("report.out_valid", 32'(out_valid), 32'd1);
      check("report.sat_valid", 32'(s_out_valid), 32'd1);
      check_result("report", sum, ferr, mx, rerr);

      for (int c = 0; c < bp; c++) begin
         start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         check("hold.out_valid", 32'(out_valid), 32'd1);
         check_result("hold", sum, ferr, mx, rerr);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("done.out_valid", 32'(out_valid), 32'd0);
      check("done.busy",      32'(busy),      32'd0);
      check("done.sat_busy",  32'(s_busy),    32'd0);
      check("done.in_ready",  32'(s_in_ready), 32'd0);
      check_result("idle_hold", sum, ferr, mx, rerr);
      tick();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; num_frames = '0; ham_dis = '0;
      in_valid = 1'b0; out_ready = 1'b0;

      // Reset with random inputs applied.
      for (int c = 0; c < 2; c++) begin
         start      = 1'($urandom);
         num_frames = 16'($urandom);
         ham_dis    = 4'($urandom);
         in_valid   = 1'($urandom);
         out_ready  = 1'($urandom);
         tick();
      end
      check("rst.in_ready",  32'(in_ready),      32'd0);
      check("rst.busy",      32'(busy),          32'd0);
      check("rst.out_valid", 32'(out_valid),     32'd0);
      check("rst.range_err", 32'(range_err),     32'd0);
      check("rst.bits",      32'(bit_err_cnt),   32'd0);
      check("rst.frames",    32'(frame_err_cnt), 32'd0);
      check("rst.max",       32'(max_dis),       32'd0);
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b1;
      tick();

      // Basic run.
      dq = '{0, 3, 12, 1};
      run_frames(4, 1'b0, 0);
      // Gaps, backpressure and ignored starts.
      dq = '{5, 0, 7};
      run_frames(3, 1'b1, 5);
      // Zero frames.
      dq = '{};
      run_frames(0, 1'b0, 2);
      // Out-of-range distances, then a clean run that must clear range_err.
      dq = '{13, 15};
      run_frames(2, 1'b0, 1);
      // Saturation of the narrow accumulator.
      dq = '{12, 12, 12};
      run_frames(3, 1'b0, 0);

      // Reset in the middle of ACCUM discards the partial run.
      start = 1'b1; num_frames = 16'd8;
      tick();
      start = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         ham_dis = 4'($urandom_range(1, 12));
         tick();
      end
      in_valid = 1'b0;
      check("midrst.pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst.busy",     32'(busy),          32'd0);
      check("midrst.in_ready", 32'(in_ready),      32'd0);
      check("midrst.bits",     32'(bit_err_cnt),   32'd0);
      check("midrst.frames",   32'(frame_err_cnt), 32'd0);
      check("midrst.max",      32'(max_dis),       32'd0);
      tick();

      // Randomized runs.
      for (int r = 0; r < 30; r++) begin
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
         dq = '{};
         for (int i = 0; i < n; i++) begin
            dq.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 15))
                                                     : int'($urandom_range(0, 12)));
         end
         run_frames(n, 1'($urandom), int'($urandom_range(0, 4)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ham_err_accum.md
Name: ham_err_accum

Overview:
Downstream consumer of the 12-bit Hamming-distance comparator. Accepts one per-frame distance (number of mismatched info bits between transmitted and estimated words) per handshake. Accumulates total bit errors, erroneous-frame count and worst-case distance over a programmed number of frames, then presents a held result through a valid/ready handshake. Feeds BER/FER reporting logic.

Parameters:
DIS_W, 4, width of incoming distance (matches comparator output)
BITS_PER_FRAME, 12, info bits per frame; legal distance range 0..BITS_PER_FRAME
FRM_W, 16, width of frame-count configuration and counters
CNT_W, 24, width of bit-error accumulator

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle pulse; begins a measurement run (honoured in IDLE only)
num_frames  in  FRM_W  frames per run, sampled on accepted start
ham_dis  in  DIS_W  per-frame Hamming distance
in_valid  in  1  ham_dis valid
in_ready  out  1  block accepts ham_dis
bit_err_cnt  out  CNT_W  sum of accepted distances
frame_err_cnt  out  FRM_W  frames with ham_dis != 0
max_dis  out  DIS_W  largest accepted distance in run
range_err  out  1  sticky: some accepted ham_dis > BITS_PER_FRAME
busy  out  1  high in ACCUM and REPORT
out_valid  out  1  result available
out_ready  in  1  consumer takes result

Behaviour:
- One clock; reset synchronous active-low: rst_n=0 sampled at a rising edge -> state IDLE; in_ready, out_valid, busy, range_err = 0; bit_err_cnt, frame_err_cnt, max_dis, internal frame counter and num_frames latch = 0. Reset has priority over every other input, including mid-run and mid-REPORT; partial results discarded.
- States: IDLE, ACCUM, REPORT. All outputs registered; in_ready = (state==ACCUM), busy = (state!=IDLE), out_valid = (state==REPORT).
- IDLE: start=1 & num_frames!=0 -> latch num_frames, clear all accumulators and range_err, frame counter=0, -> ACCUM. start=1 & num_frames==0 -> clear accumulators, -> REPORT directly (all-zero result). Previous run's results remain on outputs while in IDLE until next start.
- ACCUM: transfer when in_valid & in_ready. Per transfer (registered, visible next cycle): bit_err_cnt += ham_dis, saturating at 2^CNT_W-1; frame_err_cnt += 1 if ham_dis!=0; max_dis = max(max_dis, ham_dis); range_err |= (ham_dis > BITS_PER_FRAME); frame counter += 1. Out-of-range values still accumulated as-is.
- Transfer that makes frame counter equal latched num_frames -> REPORT on next edge; in_ready low from that cycle, so exactly num_frames transfers accepted. No transfer when in_valid=0; block waits indefinitely.
- REPORT: outputs held stable while out_valid=1 & out_ready=0. out_valid & out_ready -> IDLE next edge. out_ready may be high on REPORT entry; minimum REPORT dwell 1 cycle.
- start ignored in ACCUM and REPORT (no restart, no latch update). num_frames changes after start have no effect.
- Latency: first in_ready 1 cycle after start; out_valid 1 cycle after final transfer.
- range_err cleared only by reset or accepted start.

Test Plan:
- Reset: drive rst_n=0 for 2 clks with random inputs -> all outputs 0, state IDLE; rst_n=0 while in ACCUM after 3 frames -> next cycle busy=0, counters 0.
- Basic run: start, num_frames=4, ham_dis 0,3,12,1 continuous valid -> out_valid 1 cycle after 4th transfer; bit_err_cnt=16, frame_err_cnt=3, max_dis=12, range_err=0; exactly 4 in_ready-high cycles.
- Backpressure/gaps: num_frames=3, in_valid toggled with idle cycles, out_ready held 0 for 5 cycles -> results stable 5 cycles, IDLE one cycle after out_ready=1; start pulsed during ACCUM and REPORT ignored.
- Zero frames: start with num_frames=0 -> REPORT next cycle, all counts 0, in_ready never asserted.
- Range error: num_frames=2, ham_dis 13 then 15 -> range_err=1, bit_err_cnt=28, max_dis=15; next start clears range_err.
- Saturation: CNT_W=4 override, num_frames=3, ham_dis 12,12,12 -> bit_err_cnt=15 (saturated), frame_err_cnt=3.
